// File: rtl/branch_hazard_ctrl.sv
// ID-stage branch hazard sequencer: stalls a branch behind a load in EX/MEM,
// selects comparator forwarding sources and counts inserted stall cycles.
module branch_hazard_ctrl #(
  parameter logic [2:0] BR_OP = 3'b110,
  parameter int         CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       op_ID,
  input  logic             valid_ID,
  input  logic [4:0]       rs1_ID,
  input  logic [4:0]       rs2_ID,
  input  logic [4:0]       rd_EX,
  input  logic [4:0]       rd_MEM,
  input  logic [4:0]       rd_WB,
  input  logic             regwrite_EX,
  input  logic             regwrite_MEM,
  input  logic             regwrite_WB,
  input  logic             memread_EX,
  input  logic             memread_MEM,
  input  logic             hold,
  input  logic             flush_ID,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             idex_bubble,
  output logic [1:0]       fwd1_sel,
  output logic [1:0]       fwd2_sel,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {IDLE, WAIT_MEM, RESUME} state_t;

  state_t state, state_nxt;
  logic   br, hz_ex_ld, hz_mem_ld, stall;
  logic   m_ex1, m_ex2, m_mem1, m_mem2, m_wb1, m_wb2;
  logic [1:0] fwd1_raw, fwd2_raw;

  function automatic logic reg_match(input logic we, input logic [4:0] rd,
                                     input logic [4:0] rs);
    return we & (rd != 5'd0) & (rd == rs);
  endfunction

  // Loads in EX/MEM have no data yet, so they never act as forward sources.
  function automatic logic [1:0] fwd_pick(input logic b,
                                          input logic ex_m, input logic ex_ld,
                                          input logic mem_m, input logic mem_ld,
                                          input logic wb_m);
    if (!b)                 return 2'b00;
    else if (ex_m & !ex_ld)   return 2'b01;
    else if (mem_m & !mem_ld) return 2'b10;
    else if (wb_m)            return 2'b11;
    else                      return 2'b00;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
  endfunction

  assign br     = valid_ID & (op_ID == BR_OP);
  assign m_ex1  = reg_match(regwrite_EX,  rd_EX,  rs1_ID);
  assign m_ex2  = reg_match(regwrite_EX,  rd_EX,  rs2_ID);
  assign m_mem1 = reg_match(regwrite_MEM, rd_MEM, rs1_ID);
  assign m_mem2 = reg_match(regwrite_MEM, rd_MEM, rs2_ID);
  assign m_wb1  = reg_match(regwrite_WB,  rd_WB,  rs1_ID);
  assign m_wb2  = reg_match(regwrite_WB,  rd_WB,  rs2_ID);

  assign hz_ex_ld  = br & memread_EX  & (m_ex1  | m_ex2);
  assign hz_mem_ld = br & memread_MEM & (m_mem1 | m_mem2);

  assign fwd1_raw = fwd_pick(br, m_ex1, memread_EX, m_mem1, memread_MEM, m_wb1);
  assign fwd2_raw = fwd_pick(br, m_ex2, memread_EX, m_mem2, memread_MEM, m_wb2);

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    if (hold) begin
      state_nxt = state;
      stall     = 1'b0;
    end else if (flush_ID) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (hz_ex_ld) begin
            stall     = 1'b1;
            state_nxt = WAIT_MEM;
          end else if (hz_mem_ld) begin
            stall     = 1'b1;
            state_nxt = RESUME;
          end
        end
        WAIT_MEM: begin
          stall     = 1'b1;
          state_nxt = RESUME;
        end
        RESUME:   state_nxt = IDLE;
        default:  state_nxt = IDLE;
      endcase
    end
  end

  // Outputs are forced to their run values while reset is asserted.
  assign pc_we       = ~rst_n | (~hold & ~stall);
  assign ifid_we     = ~rst_n | (~hold & ~stall);
  assign idex_bubble = rst_n & stall;
  assign fwd1_sel    = rst_n ? fwd1_raw : 2'b00;
  assign fwd2_sel    = rst_n ? fwd2_raw : 2'b00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      stall_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (stall) stall_cnt <= sat_inc(stall_cnt);
    end
  end

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Directed bench for branch_hazard_ctrl with hand-derived expectations;
// a 4-bit counter keeps the saturation case short.
module tb_branch_hazard_ctrl;

  localparam logic [2:0] BR = 3'b110;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] op_ID;
  logic       valid_ID;
  logic [4:0] rs1_ID, rs2_ID, rd_EX, rd_MEM, rd_WB;
  logic       regwrite_EX, regwrite_MEM, regwrite_WB;
  logic       memread_EX, memread_MEM, hold, flush_ID;
  logic       pc_we, ifid_we, idex_bubble;
  logic [1:0] fwd1_sel, fwd2_sel;
  logic [3:0] stall_cnt;

  int n_cmp = 0;
  int n_err = 0;

  branch_hazard_ctrl #(.BR_OP(BR), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .op_ID(op_ID), .valid_ID(valid_ID),
    .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rd_EX(rd_EX), .rd_MEM(rd_MEM), .rd_WB(rd_WB),
    .regwrite_EX(regwrite_EX), .regwrite_MEM(regwrite_MEM), .regwrite_WB(regwrite_WB),
    .memread_EX(memread_EX), .memread_MEM(memread_MEM), .hold(hold), .flush_ID(flush_ID),
    .pc_we(pc_we), .ifid_we(ifid_we), .idex_bubble(idex_bubble),
    .fwd1_sel(fwd1_sel), .fwd2_sel(fwd2_sel), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    op_ID = 3'b000; valid_ID = 1'b0; rs1_ID = '0; rs2_ID = '0;
    rd_EX = '0; rd_MEM = '0; rd_WB = '0;
    regwrite_EX = 0; regwrite_MEM = 0; regwrite_WB = 0;
    memread_EX = 0; memread_MEM = 0; hold = 0; flush_ID = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  // beq x5,x6 in ID with lw x5 in EX
  task automatic set_ex_load_hz();
    clr();
    op_ID = BR; valid_ID = 1; rs1_ID = 5'd5; rs2_ID = 5'd6;
    rd_EX = 5'd5; regwrite_EX = 1; memread_EX = 1;
  endtask

  // the same load, advanced into MEM
  task automatic load_to_mem();
    rd_EX = 0; regwrite_EX = 0; memread_EX = 0;
    rd_MEM = 5'd5; regwrite_MEM = 1; memread_MEM = 1;
  endtask

  initial begin
    clr();
    rst_n = 1'b0;
    set_ex_load_hz();
    #2;
    chk("rst_pc_we", pc_we, 1);
    chk("rst_ifid_we", ifid_we, 1);
    chk("rst_bubble", idex_bubble, 0);
    chk("rst_fwd1", fwd1_sel, 0);
    chk("rst_cnt", stall_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Load in EX: two stalls then WB forward
    set_ex_load_hz();
    #1;
    chk("exld_c1_pc_we", pc_we, 0);
    chk("exld_c1_ifid", ifid_we, 0);
    chk("exld_c1_bubble", idex_bubble, 1);
    chk("exld_c1_fwd1", fwd1_sel, 2'b00);
    tick();
    load_to_mem();
    #1;
    chk("exld_c2_pc_we", pc_we, 0);
    chk("exld_c2_bubble", idex_bubble, 1);
    chk("exld_c2_cnt", stall_cnt, 1);
    tick();
    rd_MEM = 0; regwrite_MEM = 0; memread_MEM = 0;
    rd_WB = 5'd5; regwrite_WB = 1;
    #1;
    chk("exld_res_pc_we", pc_we, 1);
    chk("exld_res_bubble", idex_bubble, 0);
    chk("exld_res_fwd1", fwd1_sel, 2'b11);
    chk("exld_res_fwd2", fwd2_sel, 2'b00);
    chk("exld_res_cnt", stall_cnt, 2);
    tick();
    clr();
    #1;
    chk("exld_after_pc_we", pc_we, 1);
    chk("exld_after_cnt", stall_cnt, 2);

    // Load in MEM: one stall, then WB forward on rs2
    do_reset();
    clr();
    op_ID = BR; valid_ID = 1; rs1_ID = 5'd1; rs2_ID = 5'd7;
    rd_MEM = 5'd7; regwrite_MEM = 1; memread_MEM = 1;
    #1;
    chk("memld_pc_we", pc_we, 0);
    chk("memld_bubble", idex_bubble, 1);
    tick();
    rd_MEM = 0; regwrite_MEM = 0; memread_MEM = 0;
    rd_WB = 5'd7; regwrite_WB = 1;
    #1;
    chk("memld_res_pc_we", pc_we, 1);
    chk("memld_res_fwd2", fwd2_sel, 2'b11);
    chk("memld_res_fwd1", fwd1_sel, 2'b00);
    chk("memld_res_cnt", stall_cnt, 1);
    tick();

    // ALU producers: EX beats MEM, then MEM alone
    clr();
    op_ID = BR; valid_ID = 1; rs1_ID = 5'd3; rs2_ID = 5'd0;
    rd_EX = 5'd3; regwrite_EX = 1; rd_MEM = 5'd3; regwrite_MEM = 1;
    #1;
    chk("alu_pc_we", pc_we, 1);
    chk("alu_bubble", idex_bubble, 0);
    chk("alu_fwd1_ex", fwd1_sel, 2'b01);
    chk("alu_fwd2", fwd2_sel, 2'b00);
    rd_EX = 0; regwrite_EX = 0;
    #1;
    chk("alu_fwd1_mem", fwd1_sel, 2'b10);
    tick();

    // x0 load and non-branch op never stall
    clr();
    op_ID = BR; valid_ID = 1; rs1_ID = 0; rs2_ID = 0;
    rd_EX = 0; regwrite_EX = 1; memread_EX = 1;
    #1;
    chk("x0_pc_we", pc_we, 1);
    chk("x0_fwd1", fwd1_sel, 0);
    chk("x0_fwd2", fwd2_sel, 0);
    set_ex_load_hz();
    op_ID = 3'b000;
    #1;
    chk("nonbr_pc_we", pc_we, 1);
    chk("nonbr_bubble", idex_bubble, 0);
    rd_WB = 5'd6; regwrite_WB = 1;
    #1;
    chk("nonbr_fwd2", fwd2_sel, 0);
    tick();

    // Flush in WAIT_MEM returns to IDLE
    do_reset();
    set_ex_load_hz();
    tick();
    load_to_mem();
    flush_ID = 1;
    #1;
    chk("flush_pc_we", pc_we, 1);
    chk("flush_bubble", idex_bubble, 0);
    tick();
    flush_ID = 0;
    #1;
    // IDLE sees the MEM-load hazard and stalls; RESUME would not
    chk("flush_idle_pc_we", pc_we, 0);
    chk("flush_idle_cnt", stall_cnt, 1);
    tick();
    chk("flush_res_cnt", stall_cnt, 2);
    tick();

    // Hold in WAIT_MEM freezes state and counter
    do_reset();
    set_ex_load_hz();
    tick();
    load_to_mem();
    hold = 1;
    #1;
    chk("hold_pc_we", pc_we, 0);
    chk("hold_ifid", ifid_we, 0);
    chk("hold_bubble", idex_bubble, 0);
    tick(); tick(); tick();
    chk("hold_cnt", stall_cnt, 1);
    flush_ID = 1;
    tick();
    flush_ID = 0;
    hold = 0;
    #1;
    chk("hold_rel_pc_we", pc_we, 0);
    chk("hold_rel_bubble", idex_bubble, 1);
    tick();
    chk("hold_rel_cnt", stall_cnt, 2);
    chk("hold_res_pc_we", pc_we, 1);
    tick();

    // Saturation with a persistent EX-load hazard (2 stalls per 3 cycles)
    do_reset();
    set_ex_load_hz();
    for (int i = 0; i < 21; i++) tick();
    chk("sat_cnt_14", stall_cnt, 4'hE);
    for (int i = 0; i < 9; i++) tick();
    chk("sat_cnt_15", stall_cnt, 4'hF);
    chk("sat_mid_stall", pc_we, 0);
    rst_n = 1'b0;
    #1;
    chk("arst_pc_we", pc_we, 1);
    chk("arst_bubble", idex_bubble, 0);
    chk("arst_cnt", stall_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("arst_after_cnt", stall_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
